lease_expiry_tracker: RTL and testbench
=======================================

// Module: lease_expiry_tracker
// PURPOSE
//   Holds per-block lease counters for a lease cache. Drives the expired-line bit vector
//   into the victim priority encoder and takes back the encoder's index.
//   Runs a victim request/ack handshake: returns the lowest-index expired block when one
//   exists, else a round-robin fallback block. Sits between the cache controller and the
//   replacement priority encoder.
// PARAMETERS
//   CACHE_BLOCKS  128  number of tracked blocks; power of two, >=2
//   BW_LEASE      32   lease counter width (bits)
//   (local) BW_BLOCKS = `CLOG2(CACHE_BLOCKS)
// PORTS
//   clock_i           in   1             single clock, rising edge
//   resetn_i          in   1             asynchronous, active-low reset
//   ref_valid_i       in   1             one cache reference (hit or fill) this cycle
//   ref_idx_i         in   BW_BLOCKS     block referenced
//   lease_i           in   BW_LEASE      lease value to assign to ref_idx_i
//   inval_i           in   1             invalidate one block
//   inval_idx_i       in   BW_BLOCKS     block to invalidate
//   expired_o         out  CACHE_BLOCKS  bit i = ~valid[i] | (lease[i]==0); to encoder encoding_i
//   enc_idx_i         in   BW_BLOCKS     encoder binary output (lowest set bit of expired_o)
//   victim_req_i      in   1             controller requests a victim
//   victim_valid_o    out  1             victim_idx_o/victim_expired_o valid; held until ack
//   victim_idx_o      out  BW_BLOCKS     selected victim block
//   victim_expired_o  out  1             1 = victim was expired; 0 = round-robin fallback
//   victim_ack_i      in   1             controller consumed the victim
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert):
//     - lease[*]=0, valid[*]=0, so expired_o = all ones
//     - FSM=IDLE; victim_valid_o=0, victim_idx_o=0, victim_expired_o=0; rr_ptr=0
//     - Reset mid-handshake aborts the response; no ack is required afterwards.
//   Lease update, on each clock edge with ref_valid_i=1:
//     - lease[ref_idx_i] <= lease_i; valid[ref_idx_i] <= 1
//     - Every other valid block with lease!=0 decrements by 1. Counters saturate at 0
//       (no wrap) and are never touched otherwise.
//     - lease_i==0 leaves the block expired from the next cycle.
//   Invalidation, inval_i=1: valid[inval_idx_i] <= 0 and lease[inval_idx_i] <= 0.
//     - If inval_i and ref_valid_i target the same index, the reference wins.
//     - An invalidate never decrements other blocks.
//   expired_o is combinational from registers only; it never depends on same-cycle inputs.
//   Victim FSM:
//     IDLE:
//       - victim_req_i=1 -> LOOKUP. The request is sampled only in IDLE.
//     LOOKUP (1 cycle, lets the encoder settle on the registered vector):
//       - If |expired_o: victim_idx_o<=enc_idx_i, victim_expired_o<=1.
//       - Else: victim_idx_o<=rr_ptr, victim_expired_o<=0, rr_ptr<=rr_ptr+1 (wraps mod
//         CACHE_BLOCKS).
//       - Then victim_valid_o<=1 -> RESP.
//       - Selection uses pre-edge lease values. A ref_valid_i in the same cycle still
//         updates the counters but does not change this selection.
//     RESP:
//       - victim_valid_o held at 1; victim_idx_o and victim_expired_o frozen.
//       - victim_ack_i=1 -> victim_valid_o<=0 -> IDLE.
//       - A new request is accepted no earlier than the cycle after returning to IDLE.
//   Latency: request to victim_valid_o = 2 cycles (IDLE->LOOKUP->RESP).
//   The block does not itself mark the victim invalid; the controller follows up with a
//   ref (fill) or inval.
//   References and invalidates are accepted in every FSM state.
// TESTING
//   1) Reset, then victim_req_i -> victim_valid_o after 2 cycles with idx=0, expired=1;
//      expired_o=all ones.
//   2) Fill blocks 0..N-1 with lease_i=5, then 5 refs to block 0 with lease 5
//      -> blocks 1..N-1 expired, block 0 not; victim idx=1.
//   3) Fill all blocks with lease 100, request 3 victims with ack -> idx 0,1,2,
//      victim_expired_o=0; rr_ptr wraps N-1 -> 0.
//   4) Ref with lease_i=0 on block 7 while all others are live -> victim idx=7, expired=1.
//   5) ref_valid_i and inval_i on the same idx in one cycle -> block valid with the new
//      lease. Counter at 0 receiving further refs elsewhere stays 0.
//   6) Assert resetn_i low during RESP -> victim_valid_o=0 immediately, FSM IDLE,
//      all expired; hold ack low -> no stall.

Source files
------------

// File: rtl/lease_expiry_tracker.sv
// lease_expiry_tracker
//   Keeps one lease counter and one valid bit per cache block. A block is
//   "expired" when it is invalid or its lease has counted down to zero. The
//   expired vector goes out to an external priority encoder, whose lowest-set
//   index comes back on enc_idx_i. A small request/ack FSM hands the cache
//   controller a victim: the lowest expired block if any, otherwise a
//   round-robin fallback block.
//
// Ports
//   clock_i, resetn_i     clock (rising edge) and asynchronous active-low reset
//   ref_valid_i           one cache reference this cycle
//   ref_idx_i, lease_i    referenced block and the lease to load into it
//   inval_i, inval_idx_i  invalidate one block
//   expired_o             per-block expired flags, from registers only
//   enc_idx_i             encoder result for expired_o (lowest set bit)
//   victim_req_i          victim request, sampled only while idle
//   victim_valid_o        victim outputs valid, held until victim_ack_i
//   victim_idx_o          chosen victim block
//   victim_expired_o      1 = victim was expired, 0 = round-robin fallback
//   victim_ack_i          controller has consumed the victim
module lease_expiry_tracker #(
  parameter int CACHE_BLOCKS = 128,
  parameter int BW_LEASE     = 32,
  localparam int BW_BLOCKS   = $clog2(CACHE_BLOCKS)
) (
  input  logic                    clock_i,
  input  logic                    resetn_i,
  input  logic                    ref_valid_i,
  input  logic [BW_BLOCKS-1:0]    ref_idx_i,
  input  logic [BW_LEASE-1:0]     lease_i,
  input  logic                    inval_i,
  input  logic [BW_BLOCKS-1:0]    inval_idx_i,
  output logic [CACHE_BLOCKS-1:0] expired_o,
  input  logic [BW_BLOCKS-1:0]    enc_idx_i,
  input  logic                    victim_req_i,
  output logic                    victim_valid_o,
  output logic [BW_BLOCKS-1:0]    victim_idx_o,
  output logic                    victim_expired_o,
  input  logic                    victim_ack_i
);

  // Per-block lease state. Every block must decrement in parallel on a
  // reference, so the counters live in flops rather than a memory.
  for (genvar gi = 0; gi < CACHE_BLOCKS; gi++) begin : g_blk
    logic [BW_LEASE-1:0] lease_reg;
    logic                valid_reg;
    logic                ref_hit;
    logic                inval_hit;

    assign ref_hit   = ref_valid_i && (ref_idx_i == BW_BLOCKS'(gi));
    assign inval_hit = inval_i && (inval_idx_i == BW_BLOCKS'(gi));

    always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
        lease_reg <= '0;
        valid_reg <= 1'b0;
      end else if (ref_hit) begin
        // A reference beats a same-cycle invalidate of the same block.
        lease_reg <= lease_i;
        valid_reg <= 1'b1;
      end else if (inval_hit) begin
        lease_reg <= '0;
        valid_reg <= 1'b0;
      end else if (ref_valid_i && valid_reg && (lease_reg != '0)) begin
        // Only references age the other blocks; counters stop at zero.
        lease_reg <= lease_reg - BW_LEASE'(1);
      end
    end

    assign expired_o[gi] = ~valid_reg | (lease_reg == '0);
  end

  // Victim selection FSM. LOOKUP exists so the external encoder sees a
  // registered, settled expired vector before its answer is captured.
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t               state_reg;
  logic [BW_BLOCKS-1:0] rr_ptr_reg;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= '0;
      victim_valid_o   <= 1'b0;
      victim_idx_o     <= '0;
      victim_expired_o <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (victim_req_i) state_reg <= LOOKUP;
        end
        LOOKUP: begin
          if (|expired_o) begin
            victim_idx_o     <= enc_idx_i;
            victim_expired_o <= 1'b1;
          end else begin
            // Power-of-two block count, so the pointer wraps naturally.
            victim_idx_o     <= rr_ptr_reg;
            victim_expired_o <= 1'b0;
            rr_ptr_reg       <= rr_ptr_reg + BW_BLOCKS'(1);
          end
          victim_valid_o <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (victim_ack_i) begin
            victim_valid_o <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          victim_valid_o <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lease_expiry_tracker.sv
// Bench for lease_expiry_tracker with 8 blocks and 16-bit leases. The driver
// pushes the hand-computed victim into a queue; a monitor pops and compares on
// each completed handshake (valid and ack both high).
module tb_lease_expiry_tracker;
  localparam int N   = 8;
  localparam int BWL = 16;
  localparam int BWB = 3;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           ref_valid = 1'b0;
  logic [BWB-1:0] ref_idx = '0;
  logic [BWL-1:0] lease = '0;
  logic           inval = 1'b0;
  logic [BWB-1:0] inval_idx = '0;
  logic [N-1:0]   expired;
  logic [BWB-1:0] enc_idx;
  logic           victim_req = 1'b0;
  logic           victim_valid;
  logic [BWB-1:0] victim_idx;
  logic           victim_expired;
  logic           victim_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [BWB-1:0] idx;
    logic           exp;
  } vic_t;
  vic_t exp_q[$];

  lease_expiry_tracker #(.CACHE_BLOCKS(N), .BW_LEASE(BWL)) dut (
    .clock_i          (clock),
    .resetn_i         (resetn),
    .ref_valid_i      (ref_valid),
    .ref_idx_i        (ref_idx),
    .lease_i          (lease),
    .inval_i          (inval),
    .inval_idx_i      (inval_idx),
    .expired_o        (expired),
    .enc_idx_i        (enc_idx),
    .victim_req_i     (victim_req),
    .victim_valid_o   (victim_valid),
    .victim_idx_o     (victim_idx),
    .victim_expired_o (victim_expired),
    .victim_ack_i     (victim_ack)
  );

  always #5 clock = ~clock;

  // External priority encoder: index of the lowest set expired bit.
  always_comb begin
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (expired[i]) enc_idx = BWB'(i);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic rv, input logic [BWB-1:0] ri, input logic [BWL-1:0] rl,
                       input logic iv, input logic [BWB-1:0] ii);
    ref_valid = rv; ref_idx = ri; lease = rl;
    inval = iv; inval_idx = ii;
    tick();
    ref_valid = 1'b0; inval = 1'b0;
  endtask

  // Issue one victim request; optionally drive a reference during LOOKUP.
  task automatic request(input logic [BWB-1:0] eidx, input logic eexp,
                         input logic rdo, input logic [BWB-1:0] ridx, input logic [BWL-1:0] rl);
    int cnt;
    exp_q.push_back({eidx, eexp});
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    if (rdo) begin
      ref_valid = 1'b1; ref_idx = ridx; lease = rl;
    end
    tick();
    ref_valid = 1'b0;
    cnt = 2;
    while (!victim_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("req_to_valid_latency", cnt, 2);
    if (victim_valid) begin
      victim_ack = 1'b1;
      tick();
      victim_ack = 1'b0;
      chk("valid_drop_after_ack", {31'd0, victim_valid}, 0);
    end else begin
      void'(exp_q.pop_back());
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (resetn && victim_valid && victim_ack) begin
      vic_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL victim_unexpected: got idx %0d, expected no response", victim_idx);
      end else begin
        e = exp_q.pop_front();
        chk("victim_idx", {29'd0, victim_idx}, {29'd0, e.idx});
        chk("victim_expired", {31'd0, victim_expired}, {31'd0, e.exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_expired", {24'd0, expired}, 32'hFF);
    chk("reset_victim_valid", {31'd0, victim_valid}, 0);
    chk("reset_victim_idx", {29'd0, victim_idx}, 0);
    chk("reset_victim_expired", {31'd0, victim_expired}, 0);
    resetn = 1'b1;
    tick();

    // 1) Everything expired -> block 0
    request(3'd0, 1'b1, 1'b0, 3'd0, 16'd0);

    // 2) Fill with lease 5, then age everything but block 0 to zero
    for (int i = 0; i < N; i++) do_op(1'b1, BWB'(i), 16'd5, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) do_op(1'b1, 3'd0, 16'd5, 1'b0, 3'd0);
    chk("aged_expired", {24'd0, expired}, 32'hFE);
    request(3'd1, 1'b1, 1'b0, 3'd0, 16'd0);

    // 3) All live -> round-robin 0..7 then wrap to 0
    for (int i = 0; i < N; i++) do_op(1'b1, BWB'(i), 16'd100, 1'b0, 3'd0);
    chk("all_live_expired", {24'd0, expired}, 32'h00);
    for (int k = 0; k < N; k++) request(BWB'(k), 1'b0, 1'b0, 3'd0, 16'd0);
    request(3'd0, 1'b0, 1'b0, 3'd0, 16'd0);

    // 4) Zero lease on block 7
    do_op(1'b1, 3'd7, 16'd0, 1'b0, 3'd0);
    chk("zero_lease_expired", {24'd0, expired}, 32'h80);
    request(3'd7, 1'b1, 1'b0, 3'd0, 16'd0);

    // 5) Reference beats invalidate; invalidates do not age; zero stays zero
    do_op(1'b1, 3'd3, 16'd50, 1'b1, 3'd3);
    chk("ref_beats_inval", {24'd0, expired}, 32'h80);
    do_op(1'b0, 3'd0, 16'd0, 1'b1, 3'd2);
    chk("inval_block2", {24'd0, expired}, 32'h84);
    do_op(1'b1, 3'd5, 16'd1, 1'b0, 3'd0);
    chk("lease1_block5", {24'd0, expired}, 32'h84);
    do_op(1'b0, 3'd0, 16'd0, 1'b1, 3'd6);
    chk("inval_no_decrement", {24'd0, expired}, 32'hC4);
    do_op(1'b1, 3'd0, 16'd100, 1'b0, 3'd0);
    chk("ref_ages_to_zero", {24'd0, expired}, 32'hE4);
    // Reference to block 2 during LOOKUP must not change the selection
    request(3'd2, 1'b1, 1'b1, 3'd2, 16'd9);
    chk("ref_during_lookup", {24'd0, expired}, 32'hE0);

    // 6) Reset during RESP aborts the response
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    tick();
    chk("resp_valid_before_reset", {31'd0, victim_valid}, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_mid_resp_valid", {31'd0, victim_valid}, 0);
    chk("reset_mid_resp_expired", {24'd0, expired}, 32'hFF);
    chk("reset_mid_resp_idx", {29'd0, victim_idx}, 0);
    tick();
    resetn = 1'b1;
    tick();
    request(3'd0, 1'b1, 1'b0, 3'd0, 16'd0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
